// File: rtl/cpci_led_pattern_gen_if.sv
// Configuration write port of the CPCI LED pattern generator.
//   cfg_wr      : single-cycle write strobe
//   cfg_led     : target channel index
//   cfg_mode    : 0 off, 1 on, 2 pattern, 3 activity
//   cfg_pattern : slot pattern, bit s lights the LED in slot s
//   cfg_err     : one-cycle pulse when a write targets a nonexistent channel
// master = register block side, slave = pattern generator side.
interface cpci_led_pattern_gen_if;
    logic        cfg_wr;
    logic [3:0]  cfg_led;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_pattern;
    logic        cfg_err;

    modport master (
        output cfg_wr,
        output cfg_led,
        output cfg_mode,
        output cfg_pattern,
        input  cfg_err
    );

    modport slave (
        input  cfg_wr,
        input  cfg_led,
        input  cfg_mode,
        input  cfg_pattern,
        output cfg_err
    );
endinterface

// File: rtl/cpci_led_pattern_gen.sv
// Multi-channel LED pattern generator for the CPCI front panel.
// A shared prescaler produces a slow slot tick; a shared slot counter walks
// the pattern frame; each channel is off, on, pattern-driven or a stretched
// activity indicator.
//   clk, reset : system clock, synchronous active-high reset
//   cfg        : configuration write port (slave modport)
//   restart    : realign prescaler and slot counter to zero
//   activity   : per-channel activity pulses
//   tick       : one-cycle slot tick
//   slot       : current slot index
//   led_n      : registered active-low LED drive
module cpci_led_pattern_gen #(
    parameter int unsigned NUM_LEDS        = 4,
    parameter int unsigned TICK_COUNT      = 6250000,
    parameter int unsigned FRAME_LEN       = 21,
    parameter logic [31:0] DEFAULT_PATTERN = 32'h00001405,
    parameter int unsigned STRETCH_TICKS   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    cpci_led_pattern_gen_if.slave   cfg,
    input  logic                    restart,
    input  logic [NUM_LEDS-1:0]     activity,
    output logic                    tick,
    output logic [4:0]              slot,
    output logic [NUM_LEDS-1:0]     led_n
);

    localparam int unsigned CNT_W = (TICK_COUNT > 0) ? $clog2(TICK_COUNT + 1) : 1;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t       CNT_TERM     = cnt_t'(TICK_COUNT);
    localparam logic [4:0] SLOT_LAST    = 5'(FRAME_LEN - 1);
    localparam logic [3:0] STRETCH_LOAD = 4'(STRETCH_TICKS);

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_ON       = 2'd1,
        MODE_PATTERN  = 2'd2,
        MODE_ACTIVITY = 2'd3
    } mode_e;

    cnt_t                  cnt_q, cnt_d;
    logic                  tick_q, tick_d;
    logic [4:0]            slot_q, slot_d;
    logic                  cfg_err_q, cfg_err_d;
    logic [NUM_LEDS-1:0]   led_n_q, led_n_d;
    mode_e                 mode_q    [NUM_LEDS];
    mode_e                 mode_d    [NUM_LEDS];
    logic [FRAME_LEN-1:0]  pattern_q [NUM_LEDS];
    logic [FRAME_LEN-1:0]  pattern_d [NUM_LEDS];
    logic [3:0]            stretch_q [NUM_LEDS];
    logic [3:0]            stretch_d [NUM_LEDS];
    logic [31:0]           pat_ext   [NUM_LEDS];
    logic                  led_ok;
    logic                  unused_cfg_bits;

    // Pattern bits at or above FRAME_LEN are accepted on the bus but discarded.
    assign unused_cfg_bits = ^cfg.cfg_pattern;

    always_comb begin
        // restart wins over a tick being generated or consumed this cycle
        cnt_d  = (restart || cnt_q == CNT_TERM) ? '0 : cnt_q + 1'b1;
        tick_d = !restart && (cnt_q == CNT_TERM);

        slot_d = slot_q;
        if (restart) begin
            slot_d = '0;
        end else if (tick_q) begin
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 5'd1;
        end

        led_ok    = 32'(cfg.cfg_led) < NUM_LEDS;
        cfg_err_d = cfg.cfg_wr && !led_ok;

        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            mode_d[i]    = mode_q[i];
            pattern_d[i] = pattern_q[i];
            if (cfg.cfg_wr && led_ok && cfg.cfg_led == 4'(i)) begin
                mode_d[i]    = mode_e'(cfg.cfg_mode);
                pattern_d[i] = cfg.cfg_pattern[FRAME_LEN-1:0];
            end

            // A fresh pulse reloads even when a tick would decrement.
            stretch_d[i] = stretch_q[i];
            if (activity[i]) begin
                stretch_d[i] = STRETCH_LOAD;
            end else if (tick_q && stretch_q[i] != '0) begin
                stretch_d[i] = stretch_q[i] - 4'd1;
            end

            // Zero-extended so the 5-bit slot index always fits exactly.
            pat_ext[i]  = 32'(pattern_q[i]);
            led_n_d[i]  = 1'b1;
            case (mode_q[i])
                MODE_OFF:      led_n_d[i] = 1'b1;
                MODE_ON:       led_n_d[i] = 1'b0;
                MODE_PATTERN:  led_n_d[i] = ~pat_ext[i][slot_q];
                MODE_ACTIVITY: led_n_d[i] = (stretch_q[i] == '0);
                default:       led_n_d[i] = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            slot_q    <= '0;
            cfg_err_q <= 1'b0;
            led_n_q   <= '1;
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                mode_q[i]    <= MODE_PATTERN;
                pattern_q[i] <= DEFAULT_PATTERN[FRAME_LEN-1:0];
                stretch_q[i] <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            slot_q    <= slot_d;
            cfg_err_q <= cfg_err_d;
            led_n_q   <= led_n_d;
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                mode_q[i]    <= mode_d[i];
                pattern_q[i] <= pattern_d[i];
                stretch_q[i] <= stretch_d[i];
            end
        end
    end

    assign cfg.cfg_err = cfg_err_q;
    assign tick        = tick_q;
    assign slot        = slot_q;
    assign led_n       = led_n_q;

endmodule

// File: tb/tb_cpci_led_pattern_gen.sv
module tb_cpci_led_pattern_gen;

    localparam int T = 3;
    localparam int F = 21;
    localparam int N = 4;
    localparam int S = 2;
    localparam logic [31:0] DEF_PAT    = 32'h00001405;
    localparam logic [31:0] FRAME_MASK = (32'h1 << F) - 32'h1;

    logic          clk = 1'b0;
    logic          reset;
    logic          restart;
    logic [N-1:0]  activity;
    logic          tick;
    logic [4:0]    slot;
    logic [N-1:0]  led_n;

    cpci_led_pattern_gen_if cfg_if ();

    cpci_led_pattern_gen #(
        .NUM_LEDS        (N),
        .TICK_COUNT      (T),
        .FRAME_LEN       (F),
        .DEFAULT_PATTERN (DEF_PAT),
        .STRETCH_TICKS   (S)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .cfg      (cfg_if.slave),
        .restart  (restart),
        .activity (activity),
        .tick     (tick),
        .slot     (slot),
        .led_n    (led_n)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: time is counted as edges since the last realignment
    // (reset or restart); tick and slot follow arithmetically from that.
    int           m_e;
    int           m_mode [N];
    logic [31:0]  m_pat  [N];
    int           m_str  [N];
    logic [N-1:0] m_led_n;
    logic         m_err;

    typedef struct {
        logic [3:0]  led;
        logic [1:0]  mode;
        logic [31:0] pat;
        logic        exp_err;
        logic        exp_ledn;
    } vec_t;
    vec_t tbl [9];

    function automatic int m_slot(input int e);
        return (e == 0) ? 0 : ((e - 1) / (T + 1)) % F;
    endfunction

    function automatic int m_tick(input int e);
        return (e > 0 && (e % (T + 1)) == 0) ? 1 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_e = 0;
        for (int i = 0; i < N; i++) begin
            m_mode[i] = 2;
            m_pat[i]  = DEF_PAT & FRAME_MASK;
            m_str[i]  = 0;
        end
        m_led_n = '1;
        m_err   = 1'b0;
    endtask

    task automatic step(input logic wr, input logic [3:0] led, input logic [1:0] mode,
                        input logic [31:0] pat, input logic [N-1:0] act, input logic rst_in);
        int cs;
        int ct;
        logic lit;
        logic [N-1:0] nl;
        cs = m_slot(m_e);
        ct = m_tick(m_e);
        for (int i = 0; i < N; i++) begin
            case (m_mode[i])
                1:       lit = 1'b1;
                2:       lit = m_pat[i][cs];
                3:       lit = (m_str[i] != 0);
                default: lit = 1'b0;
            endcase
            nl[i] = !lit;
        end
        m_err = wr && (int'(led) >= N);
        if (wr && int'(led) < N) begin
            m_mode[led] = int'(mode);
            m_pat[led]  = pat & FRAME_MASK;
        end
        for (int i = 0; i < N; i++) begin
            if (act[i]) m_str[i] = S;
            else if (ct != 0 && m_str[i] > 0) m_str[i] = m_str[i] - 1;
        end
        m_e     = rst_in ? 0 : m_e + 1;
        m_led_n = nl;

        cfg_if.cfg_wr      = wr;
        cfg_if.cfg_led     = led;
        cfg_if.cfg_mode    = mode;
        cfg_if.cfg_pattern = pat;
        activity           = act;
        restart            = rst_in;
        @(posedge clk);
        #1;
        check("tick", 32'(tick), 32'(m_tick(m_e)));
        check("slot", 32'(slot), 32'(m_slot(m_e)));
        check("led_n", 32'(led_n), 32'(m_led_n));
        check("cfg_err", 32'(cfg_if.cfg_err), 32'(m_err));
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 2'd0, 32'h0, '0, 1'b0);
    endtask

    // Reset is given together with a write and a restart; reset must win.
    task automatic do_reset();
        reset              = 1'b1;
        cfg_if.cfg_wr      = 1'b1;
        cfg_if.cfg_led     = 4'd0;
        cfg_if.cfg_mode    = 2'd1;
        cfg_if.cfg_pattern = 32'hFFFFFFFF;
        restart            = 1'b1;
        activity           = '1;
        @(posedge clk);
        #1;
        model_reset();
        check("rst_led_n", 32'(led_n), 32'hF);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_slot", 32'(slot), 32'h0);
        check("rst_cfg_err", 32'(cfg_if.cfg_err), 32'h0);
        reset              = 1'b0;
        cfg_if.cfg_wr      = 1'b0;
        restart            = 1'b0;
        activity           = '0;
    endtask

    task automatic align_to_tick();
        for (int k = 0; k < T + 2; k++) begin
            if (tick === 1'b1) break;
            idle();
        end
        check("align_tick", 32'(tick), 32'h1);
    endtask

    initial begin
        int cnt;
        int max_slot;
        reset              = 1'b0;
        restart            = 1'b0;
        activity           = '0;
        cfg_if.cfg_wr      = 1'b0;
        cfg_if.cfg_led     = '0;
        cfg_if.cfg_mode    = '0;
        cfg_if.cfg_pattern = '0;

        tbl[0] = '{4'd2,  2'd1, 32'h00000000, 1'b0, 1'b0};
        tbl[1] = '{4'd2,  2'd0, 32'h00000000, 1'b0, 1'b1};
        tbl[2] = '{4'd1,  2'd2, 32'hFFE00000, 1'b0, 1'b1};
        tbl[3] = '{4'd0,  2'd2, 32'h001FFFFF, 1'b0, 1'b0};
        tbl[4] = '{4'd4,  2'd1, 32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[5] = '{4'd15, 2'd3, 32'h00000000, 1'b1, 1'b0};
        tbl[6] = '{4'd3,  2'd3, 32'h00000000, 1'b0, 1'b1};
        tbl[7] = '{4'd0,  2'd1, 32'h00000000, 1'b0, 1'b0};
        tbl[8] = '{4'd2,  2'd2, 32'h00000000, 1'b0, 1'b1};

        @(posedge clk);
        #1;
        do_reset();

        // First tick appears after the counter has run 0..T.
        cnt = 0;
        while (tick !== 1'b1 && cnt < 20) begin
            idle();
            cnt++;
        end
        check("first_tick_delay", 32'(cnt), 32'(T + 1));

        // One full frame of the default heartbeat on channel 0.
        cnt = 0;
        max_slot = 0;
        for (int k = 0; k < F * (T + 1); k++) begin
            idle();
            if (led_n[0] === 1'b0) cnt++;
            if (int'(slot) > max_slot) max_slot = int'(slot);
        end
        check("heartbeat_lit_cycles", 32'(cnt), 32'(4 * (T + 1)));
        check("slot_max", 32'(max_slot), 32'(F - 1));

        // Table of configuration writes.
        for (int v = 0; v < 9; v++) begin
            step(1'b1, tbl[v].led, tbl[v].mode, tbl[v].pat, '0, 1'b0);
            check("tbl_err", 32'(cfg_if.cfg_err), 32'(tbl[v].exp_err));
            idle();
            if (!tbl[v].exp_err) check("tbl_led", 32'(led_n[tbl[v].led]), 32'(tbl[v].exp_ledn));
            else                 check("tbl_err_clear", 32'(cfg_if.cfg_err), 32'h0);
        end

        // Back-to-back writes to one channel: last wins.
        step(1'b1, 4'd2, 2'd1, 32'h0, '0, 1'b0);
        step(1'b1, 4'd2, 2'd0, 32'h0, '0, 1'b0);
        check("b2b_first", 32'(led_n[2]), 32'h0);
        idle();
        check("b2b_last", 32'(led_n[2]), 32'h1);

        // Channel 1 lit only in slots 0 and 20, then never with high-only bits.
        step(1'b1, 4'd1, 2'd2, 32'h00100001, '0, 1'b0);
        cnt = 0;
        for (int k = 0; k < F * (T + 1); k++) begin
            idle();
            if (led_n[1] === 1'b0) cnt++;
        end
        check("ch1_two_slots", 32'(cnt), 32'(2 * (T + 1)));
        step(1'b1, 4'd1, 2'd2, 32'hFFE00000, '0, 1'b0);
        cnt = 0;
        for (int k = 0; k < F * (T + 1); k++) begin
            idle();
            if (led_n[1] === 1'b0) cnt++;
        end
        check("ch1_high_bits_ignored", 32'(cnt), 32'h0);

        // Channel 3 (activity mode) single pulse mid-tick-period:
        // lit for 7 cycles, dark once the second following tick has been applied.
        align_to_tick();
        idle();
        step(1'b0, 4'd0, 2'd0, 32'h0, 4'b1000, 1'b0);
        for (int j = 1; j <= 8; j++) begin
            idle();
            check("stretch_single", 32'(led_n[3]), (j <= 7) ? 32'h0 : 32'h1);
        end

        // Pulse coincident with a tick reloads rather than decrements.
        align_to_tick();
        step(1'b0, 4'd0, 2'd0, 32'h0, 4'b1000, 1'b0);
        for (int j = 1; j <= 9; j++) begin
            idle();
            check("stretch_on_tick", 32'(led_n[3]), (j <= 8) ? 32'h0 : 32'h1);
        end

        // restart in the cycle a tick would be generated.
        align_to_tick();
        for (int k = 0; k < T; k++) idle();
        step(1'b0, 4'd0, 2'd0, 32'h0, '0, 1'b1);
        check("restart_tick", 32'(tick), 32'h0);
        check("restart_slot", 32'(slot), 32'h0);
        cnt = 0;
        while (tick !== 1'b1 && cnt < 20) begin
            idle();
            cnt++;
        end
        // T+2 cycles counted from the cycle restart was asserted.
        check("restart_next_tick", 32'(cnt + 1), 32'(T + 2));

        // Randomized traffic against the model.
        for (int k = 0; k < 800; k++) begin
            logic [N-1:0] act;
            for (int i = 0; i < N; i++) act[i] = ($urandom_range(0, 15) == 0);
            step($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 $urandom, act, $urandom_range(0, 49) == 0);
        end

        do_reset();
        for (int k = 0; k < 300; k++) begin
            logic [N-1:0] act;
            for (int i = 0; i < N; i++) act[i] = ($urandom_range(0, 11) == 0);
            step($urandom_range(0, 4) == 0, 4'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 $urandom, act, $urandom_range(0, 79) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
